// File: rtl/fbuf_rect_writer_if.sv
// rtl/fbuf_rect_writer_if.sv - command handshake and framebuffer write port bundle for the rectangle writer
interface fbuf_rect_writer_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLOR_W = 4
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_clear;
    logic [X_W-1:0]       cmd_x0;
    logic [Y_W-1:0]       cmd_y0;
    logic [X_W-1:0]       cmd_x1;
    logic [Y_W-1:0]       cmd_y1;
    logic [COLOR_W-1:0]   cmd_color;
    logic                 busy;
    logic                 done;
    logic [X_W+Y_W-1:0]   fb_waddr;
    logic [COLOR_W-1:0]   fb_din;
    logic                 fb_we;

    // Command source side (CPU / UART front-end, or a testbench)
    modport master (
        output cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, busy, done, fb_waddr, fb_din, fb_we
    );

    // Fill engine side
    modport slave (
        input  cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, busy, done, fb_waddr, fb_din, fb_we
    );
endinterface

// File: rtl/fbuf_rect_writer.sv
// rtl/fbuf_rect_writer.sv - rectangle-fill / clear engine streaming one framebuffer write per clock
module fbuf_rect_writer #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLOR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    fbuf_rect_writer_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [X_W-1:0]       xmin_q, xmin_d;
    logic [X_W-1:0]       xmax_q, xmax_d;
    logic [Y_W-1:0]       ymin_q, ymin_d;
    logic [Y_W-1:0]       ymax_q, ymax_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [X_W-1:0]       cmd_xlo, cmd_xhi;
    logic [Y_W-1:0]       cmd_ylo, cmd_yhi;
    logic                 at_last;

    // Ready is forced low while rst is asserted so a command coinciding with reset is never taken
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // Normalise the two corners into an unsigned bounding box; clear overrides with the full screen
    always_comb begin
        cmd_xlo = '0;
        cmd_xhi = '1;
        cmd_ylo = '0;
        cmd_yhi = '1;
        if (!bus.cmd_clear) begin
            cmd_xlo = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
            cmd_xhi = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
            cmd_ylo = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
            cmd_yhi = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;
        end
    end

    // The cursor always names the pixel being written this cycle, so equality with the far corner ends the fill
    assign at_last = (x_q == xmax_q) && (y_q == ymax_q);

    // Next-state and next-output logic; the cursor is preloaded at accept so the first write follows immediately
    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    xmin_d  = cmd_xlo;
                    xmax_d  = cmd_xhi;
                    ymin_d  = cmd_ylo;
                    ymax_d  = cmd_yhi;
                    x_d     = cmd_xlo;
                    y_d     = cmd_ylo;
                    color_d = bus.cmd_color;
                    we_d    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (at_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (x_q < xmax_q) begin
                    x_d  = x_q + X_ONE;
                    we_d = 1'b1;
                end else begin
                    x_d  = xmin_q;
                    y_d  = y_q + Y_ONE;
                    we_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, cursor and registered write-port outputs; reset aborts any fill in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == FILL);
    assign bus.done     = done_q;
    assign bus.fb_we    = we_q;
    assign bus.fb_waddr = {y_q, x_q};
    assign bus.fb_din   = color_q;

endmodule

// File: tb/tb_fbuf_rect_writer.sv
// tb/tb_fbuf_rect_writer.sv - scoreboard bench for the framebuffer rectangle writer
module tb_fbuf_rect_writer;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  din;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fbuf_rect_writer_if #(.X_W(6), .Y_W(6), .COLOR_W(4)) bus ();

    fbuf_rect_writer #(.X_W(6), .Y_W(6), .COLOR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    logic exp_done = 1'b0;
    logic mid      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write against the scoreboard and checks done / gap-free streaming
    always @(negedge clk) begin
        exp_t e;
        if (exp_done || bus.done === 1'b1) begin
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL done_pulse: got %0b expected %0b", bus.done, exp_done);
            end
        end
        exp_done = 1'b0;
        if (mid && bus.fb_we !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL write_gap: got fb_we=%0b expected 1", bus.fb_we);
            mid = 1'b0;
        end
        if (bus.fb_we === 1'b1) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_flags: got busy=%0b ready=%0b expected busy=1 ready=0", bus.busy, bus.cmd_ready);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h din=%0h expected no write", bus.fb_waddr, bus.fb_din);
            end else begin
                e = sb.pop_front();
                if (bus.fb_waddr !== e.addr || bus.fb_din !== e.din) begin
                    errors++;
                    $display("FAIL write: got addr=%0h din=%0h expected addr=%0h din=%0h",
                             bus.fb_waddr, bus.fb_din, e.addr, e.din);
                end
                exp_done = e.last;
                mid      = !e.last;
            end
            wr_count++;
        end
    end

    // Reference model: every pixel of the normalised bounding box, row-major
    task automatic push_rect(input bit clr, input int x0, input int y0, input int x1, input int y1, input int col);
        int   xl, xh, yl, yh;
        exp_t e;
        if (clr) begin
            xl = 0; xh = 63; yl = 0; yh = 63;
        end else begin
            xl = (x0 < x1) ? x0 : x1;
            xh = (x0 < x1) ? x1 : x0;
            yl = (y0 < y1) ? y0 : y1;
            yh = (y0 < y1) ? y1 : y0;
        end
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                e.addr = 12'(y * 64 + x);
                e.din  = 4'(col);
                e.last = (x == xh) && (y == yh);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_lit(input logic [11:0] a, input logic [3:0] d, input logic l);
        exp_t e;
        e.addr = a;
        e.din  = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic scramble_cmd();
        bus.cmd_clear = 1'($urandom);
        bus.cmd_x0    = 6'($urandom);
        bus.cmd_y0    = 6'($urandom);
        bus.cmd_x1    = 6'($urandom);
        bus.cmd_y1    = 6'($urandom);
        bus.cmd_color = 4'($urandom);
    endtask

    // Entered just after a rising edge; returns just after the accepting edge
    task automatic issue(input bit clr, input int x0, input int y0, input int x1, input int y1,
                         input int col, output bit in_done);
        bit acc;
        acc           = 1'b0;
        in_done       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = clr;
        bus.cmd_x0    = 6'(x0);
        bus.cmd_y0    = 6'(y0);
        bus.cmd_x1    = 6'(x1);
        bus.cmd_y1    = 6'(y1);
        bus.cmd_color = 4'(col);
        for (int i = 0; i < 6000 && !acc; i++) begin
            @(negedge clk);
            acc     = (bus.cmd_valid && bus.cmd_ready === 1'b1 && !rst);
            in_done = (bus.done === 1'b1);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 6000 cycles");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !exp_done && bus.busy !== 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got %0d pending writes expected 0", sb.size());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before 3ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit in_done;
        int busy_cnt, base, n;
        int x0, y0, x1, y1, col, area;
        bit b2b;

        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_we",    32'(bus.fb_we),     32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_waddr", 32'(bus.fb_waddr),  32'd0);
        chk("rst_din",   32'(bus.fb_din),    32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Rect fill with a command waved at the engine while it is busy
        push_lit(12'h0C2, 4'hA, 1'b0); push_lit(12'h0C3, 4'hA, 1'b0); push_lit(12'h0C4, 4'hA, 1'b0);
        push_lit(12'h102, 4'hA, 1'b0); push_lit(12'h103, 4'hA, 1'b0); push_lit(12'h104, 4'hA, 1'b1);
        issue(1'b0, 2, 3, 4, 4, 4'hA, in_done);
        bus.cmd_valid = 1'b1;
        repeat (4) begin
            scramble_cmd();
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        wait_idle();

        // Swapped corners
        push_lit(12'h0C2, 4'hA, 1'b0); push_lit(12'h0C3, 4'hA, 1'b0); push_lit(12'h0C4, 4'hA, 1'b0);
        push_lit(12'h102, 4'hA, 1'b0); push_lit(12'h103, 4'hA, 1'b0); push_lit(12'h104, 4'hA, 1'b1);
        issue(1'b0, 4, 4, 2, 3, 4'hA, in_done);
        wait_idle();

        // Full clear with random (ignored) coordinates
        push_rect(1'b1, 0, 0, 0, 0, 0);
        issue(1'b1, 9, 40, 17, 3, 0, in_done);
        busy_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            busy_cnt++;
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd4096);
        wait_idle();

        // Back-to-back: single pixel, then a second command held valid
        push_lit(12'hFFF, 4'hF, 1'b1);
        issue(1'b0, 63, 63, 63, 63, 4'hF, in_done);
        push_rect(1'b0, 1, 0, 0, 0, 5);
        issue(1'b0, 1, 0, 0, 0, 5, in_done);
        chk("b2b_accept_in_done", 32'(in_done), 32'd1);
        @(negedge clk);
        chk("b2b_first_we",    32'(bus.fb_we),    32'd1);
        chk("b2b_first_waddr", 32'(bus.fb_waddr), 32'h000);
        @(posedge clk);
        #1;
        wait_idle();

        // Reset on the 10th write of a clear
        push_rect(1'b1, 0, 0, 0, 0, 3);
        issue(1'b1, 0, 0, 0, 0, 3, in_done);
        base = wr_count;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        mid      = 1'b0;
        exp_done = 1'b0;
        @(negedge clk);
        chk("abort_we",     32'(bus.fb_we),     32'd0);
        chk("abort_busy",   32'(bus.busy),      32'd0);
        chk("abort_ready",  32'(bus.cmd_ready), 32'd1);
        chk("abort_writes", 32'(wr_count - base), 32'd10);
        @(posedge clk);
        #1;
        push_rect(1'b0, 5, 7, 5, 7, 9);
        issue(1'b0, 5, 7, 5, 7, 9, in_done);
        wait_idle();

        // Randomised rectangles with gaps, back-to-back issue and busy-time noise
        for (int k = 0; k < 25; k++) begin
            x0   = $urandom_range(0, 63);
            y0   = $urandom_range(0, 63);
            x1   = $urandom_range(0, 63);
            y1   = $urandom_range(0, 63);
            col  = $urandom_range(0, 15);
            area = ((x0 > x1 ? x0 - x1 : x1 - x0) + 1) * ((y0 > y1 ? y0 - y1 : y1 - y0) + 1);
            b2b  = 1'($urandom);
            push_rect(1'b0, x0, y0, x1, y1, col);
            issue(1'b0, x0, y0, x1, y1, col, in_done);
            if (!b2b) begin
                if (area >= 6) begin
                    bus.cmd_valid = 1'b1;
                    repeat (4) begin
                        scramble_cmd();
                        @(posedge clk);
                        #1;
                    end
                    bus.cmd_valid = 1'b0;
                end
                wait_idle();
                n = $urandom_range(0, 3);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fbuf_rect_writer.md
Name: fbuf_rect_writer

Overview:
- Write-side engine for the 64x64 HUB75 framebuffer; the LED controller is the read side.
- Accepts rectangle-fill and full-screen-clear commands over a valid/ready handshake.
- Streams one framebuffer write per clock, in row-major order, to the framebuffer write port (waddr/din/we).
- Lets the CPU or a UART front-end draw without per-pixel bus traffic.

Parameters:
- X_W, 6, column coordinate width (64 columns).
- Y_W, 6, row coordinate width (64 rows; MSB selects top/bottom half, matching read addresses {half, row_addr, col_addr}).
- COLOR_W, 4, pixel colour width (framebuffer din width).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command this cycle
- cmd_clear  in  1  1 = fill entire screen, ignore coordinates
- cmd_x0  in  X_W  first corner column
- cmd_y0  in  Y_W  first corner row
- cmd_x1  in  X_W  second corner column
- cmd_y1  in  Y_W  second corner row
- cmd_color  in  COLOR_W  fill colour
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse after the last pixel write
- fb_waddr  out  X_W+Y_W  framebuffer write address = {y, x}
- fb_din  out  COLOR_W  framebuffer write data
- fb_we  out  1  framebuffer write enable

Behaviour:
- Reset values: cmd_ready=0 during rst, 1 in the first cycle after rst deasserts. busy=0, done=0, fb_we=0, fb_waddr=0, fb_din=0. State=IDLE.
- Clock and reset: single clock domain; reset is synchronous and active-high. rst is sampled on the clk rising edge and overrides everything.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - FILL: cmd_ready=0, busy=1.
- Accept: cmd_valid && cmd_ready at an edge.
  - Latch xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1), colour.
  - If cmd_clear=1: xmin=0, xmax=2^X_W-1, ymin=0, ymax=2^Y_W-1.
  - Go to FILL with cursor (x,y)=(xmin,ymin).
- FILL, every cycle:
  - fb_we=1, fb_waddr={y,x}, fb_din=latched colour. Outputs are registered.
  - First write appears in the cycle after the accept edge.
  - Cursor advance: if x<xmax then x+1; else x=xmin and y=y+1.
  - After the write at (xmax,ymax): return to IDLE.
- Timing: a W x H rectangle takes exactly W*H consecutive fb_we cycles, with no gaps.
  - Full clear = 4096 cycles.
  - Single pixel (x0=x1, y0=y1) = 1 write.
- done:
  - High for exactly one cycle: the first IDLE cycle after the last write.
  - cmd_ready is also 1 in that cycle, so a back-to-back command is accepted with zero bubble beyond that cycle.
- Command handling:
  - While busy, cmd_valid is ignored (not latched). Command inputs must only be sampled at the accept edge.
  - Coordinate comparisons are unsigned.
  - Cursor counters are X_W/Y_W wide. Wrap at 63->0 never occurs because termination is on equality with max.
- Outside FILL: fb_we=0. fb_waddr and fb_din hold their last values.
- Reset mid-fill: at the edge where rst=1, abort immediately. fb_we=0 and busy=0 from the next cycle; no done pulse; partial writes remain in the framebuffer.
- A command presented in the same cycle as rst is dropped.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> cmd_ready=1, fb_we=0, busy=0, done never pulses.
- Rect fill: x0=2,y0=3,x1=4,y1=4,color=0xA.
  - 6 consecutive fb_we cycles, addresses {3,2},{3,3},{3,4},{4,2},{4,3},{4,4} (0x0C2, 0x0C3, 0x0C4, 0x102, 0x103, 0x104), fb_din=0xA.
  - done pulses 1 cycle after the last write.
- Swapped corners: x0=4,y0=4,x1=2,y1=3 -> identical write sequence to the previous scenario.
- Clear + bottom-half boundary: cmd_clear=1, color=0x0.
  - 4096 writes, 0x000..0xFFF in order.
  - Row 31 -> 32 crossing goes 0x7FF -> 0x800 (top-to-bottom half).
  - busy high for exactly 4096 cycles.
- Back-to-back commands:
  - Single pixel (63,63,0xF): one write at 0xFFF.
  - Second command held valid: accepted in the done cycle; its first write follows in the next cycle.
  - cmd_valid asserted while busy is ignored.
- Reset mid-fill: assert rst on the 10th write of a clear -> fb_we=0 next cycle, no done pulse, cmd_ready=1 after release.
  - A subsequent 1-pixel command completes normally.
